// File: rtl/conv_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sequencer_if
// Description : Control, configuration and memory-port bundle of the
//               convolution layer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_layer_sequencer_if #(
    parameter int DIM_AW = 9,
    parameter int BVM_AW = 10,
    parameter int OUT_AW = 9
) ();
    logic              xxx__dut__go;
    logic              dut__xxx__finish;
    logic [DIM_AW-1:0] cfg_in_base;
    logic [BVM_AW-1:0] cfg_wt_base;
    logic [OUT_AW-1:0] cfg_out_base;
    logic              stall;
    logic [DIM_AW-1:0] dut__dim__address;
    logic              dut__dim__enable;
    logic [BVM_AW-1:0] dut__bvm__address;
    logic              dut__bvm__enable;
    logic [OUT_AW-1:0] dut__out__address;
    logic              dut__out__enable;
    logic              dut__out__write;
    logic              acc_first;
    logic              acc_last;
    logic              clear;

    // Host side: starts runs, supplies bases and back-pressure.
    modport master (
        output xxx__dut__go, cfg_in_base, cfg_wt_base, cfg_out_base, stall,
        input  dut__xxx__finish, dut__dim__address, dut__dim__enable,
               dut__bvm__address, dut__bvm__enable, dut__out__address,
               dut__out__enable, dut__out__write, acc_first, acc_last, clear
    );

    modport slave (
        input  xxx__dut__go, cfg_in_base, cfg_wt_base, cfg_out_base, stall,
        output dut__xxx__finish, dut__dim__address, dut__dim__enable,
               dut__bvm__address, dut__bvm__enable, dut__out__address,
               dut__out__enable, dut__out__write, acc_first, acc_last, clear
    );
endinterface
`default_nettype wire

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sequencer
// Description : Parametrised read/drain/write address sequencer for one
//               convolution layer, with stall and runtime base addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
    parameter int K           = 3,
    parameter int ROW_STRIDE  = 16,
    parameter int OUT_W       = 4,
    parameter int OUT_H       = 4,
    parameter int NUM_FILTERS = 4,
    parameter int WT_STRIDE   = 16,
    parameter int ACC_LAT     = 5,
    parameter int DIM_AW      = 9,
    parameter int BVM_AW      = 10,
    parameter int OUT_AW      = 9
) (
    input logic                   clk,
    input logic                   reset,
    conv_layer_sequencer_if.slave bus
);

    localparam int c_KW = (K > 1)           ? $clog2(K)           : 1;
    localparam int c_XW = (OUT_W > 1)       ? $clog2(OUT_W)       : 1;
    localparam int c_YW = (OUT_H > 1)       ? $clog2(OUT_H)       : 1;
    localparam int c_FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int c_LW = (ACC_LAT > 1)     ? $clog2(ACC_LAT)     : 1;

    localparam logic [c_KW-1:0] c_K_LAST   = c_KW'(K - 1);
    localparam logic [c_XW-1:0] c_X_LAST   = c_XW'(OUT_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST   = c_YW'(OUT_H - 1);
    localparam logic [c_FW-1:0] c_F_LAST   = c_FW'(NUM_FILTERS - 1);
    localparam logic [c_LW-1:0] c_LAT_LAST = c_LW'(ACC_LAT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_WRITE = 2'd3;

    logic [1:0]        r_state;
    logic [c_KW-1:0]   r_kx;
    logic [c_KW-1:0]   r_ky;
    logic [c_XW-1:0]   r_ox;
    logic [c_YW-1:0]   r_oy;
    logic [c_FW-1:0]   r_f;
    logic [c_LW-1:0]   r_lat;
    logic [DIM_AW-1:0] r_in_base;
    logic [BVM_AW-1:0] r_wt_base;
    logic [OUT_AW-1:0] r_out_base;

    logic w_read;
    logic w_write;
    logic w_last_point;

    assign w_read       = (r_state == c_READ)  && !bus.stall;
    assign w_write      = (r_state == c_WRITE) && !bus.stall;
    assign w_last_point = (r_ox == c_X_LAST) && (r_oy == c_Y_LAST) && (r_f == c_F_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_kx       <= '0;
            r_ky       <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_f        <= '0;
            r_lat      <= '0;
            r_in_base  <= '0;
            r_wt_base  <= '0;
            r_out_base <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.xxx__dut__go) begin
                        r_in_base  <= bus.cfg_in_base;
                        r_wt_base  <= bus.cfg_wt_base;
                        r_out_base <= bus.cfg_out_base;
                        r_kx       <= '0;
                        r_ky       <= '0;
                        r_ox       <= '0;
                        r_oy       <= '0;
                        r_f        <= '0;
                        r_lat      <= '0;
                        r_state    <= c_READ;
                    end
                end
                c_READ: begin
                    if (!bus.stall) begin
                        if (r_kx == c_K_LAST) begin
                            r_kx <= '0;
                            if (r_ky == c_K_LAST) begin
                                r_ky    <= '0;
                                r_lat   <= '0;
                                r_state <= c_DRAIN;
                            end else begin
                                r_ky <= r_ky + c_KW'(1);
                            end
                        end else begin
                            r_kx <= r_kx + c_KW'(1);
                        end
                    end
                end
                c_DRAIN: begin
                    if (!bus.stall) begin
                        if (r_lat == c_LAT_LAST) begin
                            r_state <= c_WRITE;
                        end else begin
                            r_lat <= r_lat + c_LW'(1);
                        end
                    end
                end
                c_WRITE: begin
                    // Point order: ox fastest, then oy, then filter.
                    if (!bus.stall) begin
                        if (r_ox == c_X_LAST) begin
                            r_ox <= '0;
                            if (r_oy == c_Y_LAST) begin
                                r_oy <= '0;
                                if (r_f == c_F_LAST) begin
                                    r_f <= '0;
                                end else begin
                                    r_f <= r_f + c_FW'(1);
                                end
                            end else begin
                                r_oy <= r_oy + c_YW'(1);
                            end
                        end else begin
                            r_ox <= r_ox + c_XW'(1);
                        end
                        r_state <= w_last_point ? c_IDLE : c_READ;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Addresses are decoded from held indices, so a stall freezes them.
    assign bus.dut__dim__address = DIM_AW'(32'(r_in_base)
                                 + (32'(r_oy) + 32'(r_ky)) * 32'(ROW_STRIDE)
                                 + 32'(r_ox) + 32'(r_kx));
    assign bus.dut__bvm__address = BVM_AW'(32'(r_wt_base)
                                 + 32'(r_f) * 32'(WT_STRIDE)
                                 + 32'(r_ky) * 32'(K) + 32'(r_kx));
    assign bus.dut__out__address = OUT_AW'(32'(r_out_base)
                                 + 32'(r_f) * 32'(OUT_W * OUT_H)
                                 + 32'(r_oy) * 32'(OUT_W) + 32'(r_ox));

    assign bus.dut__xxx__finish = (r_state == c_IDLE);
    assign bus.dut__dim__enable = w_read;
    assign bus.dut__bvm__enable = w_read;
    assign bus.acc_first        = w_read && (r_ky == '0) && (r_kx == '0);
    assign bus.acc_last         = w_read && (r_ky == c_K_LAST) && (r_kx == c_K_LAST);
    assign bus.dut__out__enable = w_write;
    assign bus.dut__out__write  = w_write;
    assign bus.clear            = w_write;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_layer_sequencer
// Description : Scoreboard bench: loop-nest reference model vs. sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

    localparam int c_K = 3, c_RS = 16, c_OW = 4, c_OH = 4, c_NF = 4, c_WS = 16, c_LAT = 5;
    localparam int c_PT    = c_K * c_K + c_LAT + 1;
    localparam int c_TOTAL = c_NF * c_OW * c_OH * c_PT;

    typedef struct {
        int dim;
        int bvm;
        int first;
        int last;
        int slot;
    } rd_t;

    typedef struct {
        int addr;
        int slot;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    rd_t  rq[$];
    wr_t  wq[$];
    int   slot;
    bit   prev_run = 1'b0;

    conv_layer_sequencer_if #(.DIM_AW(9), .BVM_AW(10), .OUT_AW(9)) bus ();
    conv_layer_sequencer_if #(.DIM_AW(9), .BVM_AW(10), .OUT_AW(9)) bus2 ();

    conv_layer_sequencer u_dut (.clk(clk), .reset(reset), .bus(bus));

    conv_layer_sequencer #(
        .K(2), .ROW_STRIDE(16), .OUT_W(3), .OUT_H(1), .NUM_FILTERS(2),
        .WT_STRIDE(16), .ACC_LAT(1), .DIM_AW(9), .BVM_AW(10), .OUT_AW(9)
    ) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference schedule: one slot per non-stalled cycle after go.
    function automatic void push_run(input int ib, input int wb, input int ob);
        int  p = 0;
        rd_t r;
        wr_t w;
        for (int f = 0; f < c_NF; f++)
            for (int oy = 0; oy < c_OH; oy++)
                for (int ox = 0; ox < c_OW; ox++) begin
                    for (int j = 0; j < c_K * c_K; j++) begin
                        r.dim   = (ib + (oy + j / c_K) * c_RS + ox + j % c_K) % 512;
                        r.bvm   = (wb + f * c_WS + j) % 1024;
                        r.first = (j == 0) ? 1 : 0;
                        r.last  = (j == c_K * c_K - 1) ? 1 : 0;
                        r.slot  = p * c_PT + j + 1;
                        rq.push_back(r);
                    end
                    w.addr = (ob + f * c_OW * c_OH + oy * c_OW + ox) % 512;
                    w.slot = (p + 1) * c_PT;
                    wq.push_back(w);
                    p++;
                end
    endfunction

    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        if (reset) begin
            prev_run = 1'b0;
        end else if (!bus.dut__xxx__finish) begin
            if (!prev_run) slot = 0;
            prev_run = 1'b1;
            if (!bus.stall) slot++;
            else chk("stall_gating", int'({bus.dut__dim__enable, bus.dut__bvm__enable,
                     bus.dut__out__enable, bus.dut__out__write, bus.clear,
                     bus.acc_first, bus.acc_last}), 0);
            if (bus.dut__out__enable || bus.dut__out__write || bus.clear) begin
                chk("clear_eq_write", int'(bus.clear), int'(bus.dut__out__write));
                chk("oen_eq_write", int'(bus.dut__out__enable), int'(bus.dut__out__write));
            end
            if (bus.dut__dim__enable || bus.dut__bvm__enable) begin
                chk("rd_en_pair", int'(bus.dut__dim__enable), int'(bus.dut__bvm__enable));
                if (rq.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    r = rq.pop_front();
                    chk("rd_dim", int'(bus.dut__dim__address), r.dim);
                    chk("rd_bvm", int'(bus.dut__bvm__address), r.bvm);
                    chk("rd_first", int'(bus.acc_first), r.first);
                    chk("rd_last", int'(bus.acc_last), r.last);
                    chk("rd_slot", slot, r.slot);
                end
            end else if (bus.acc_first || bus.acc_last) begin
                chk("tag_without_read", 1, 0);
            end
            if (bus.dut__out__write) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", int'(bus.dut__out__address), w.addr);
                    chk("wr_slot", slot, w.slot);
                end
            end
        end else if (prev_run) begin
            prev_run = 1'b0;
            chk("run_len", slot, c_TOTAL);
            chk("rd_left", rq.size(), 0);
            chk("wr_left", wq.size(), 0);
        end
    end

    task automatic do_go(input int ib, input int wb, input int ob);
        @(posedge clk); #1;
        bus.cfg_in_base  = 9'(ib);
        bus.cfg_wt_base  = 10'(wb);
        bus.cfg_out_base = 9'(ob);
        bus.xxx__dut__go = 1'b1;
        push_run(ib, wb, ob);
        @(posedge clk); #1;
        bus.xxx__dut__go = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (bus.dut__xxx__finish) done = 1'b1;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int found;
        int fin;
        int dq[$];
        int bq[$];
        int wa[$];

        reset = 1'b1;
        bus.xxx__dut__go = 1'b0; bus.stall = 1'b0;
        bus.cfg_in_base = '0; bus.cfg_wt_base = '0; bus.cfg_out_base = '0;
        bus2.xxx__dut__go = 1'b0; bus2.stall = 1'b0;
        bus2.cfg_in_base = '0; bus2.cfg_wt_base = '0; bus2.cfg_out_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_finish", int'(bus.dut__xxx__finish), 1);
        chk("rst_enables", int'({bus.dut__dim__enable, bus.dut__bvm__enable,
            bus.dut__out__enable, bus.dut__out__write, bus.clear, bus.acc_first, bus.acc_last}), 0);
        chk("rst_dim_addr", int'(bus.dut__dim__address), 0);
        chk("rst_bvm_addr", int'(bus.dut__bvm__address), 0);
        chk("rst_out_addr", int'(bus.dut__out__address), 0);

        // Go while reset is held: reset wins.
        @(posedge clk); #1 bus.xxx__dut__go = 1'b1;
        @(posedge clk); #1 bus.xxx__dut__go = 1'b0;
        @(negedge clk);
        chk("go_vs_reset", int'(bus.dut__xxx__finish), 1);
        @(posedge clk); #1 reset = 1'b0;

        // Run A: default bases, no stall.
        do_go(0, 0, 0);
        wait_idle(2000, "runA");

        // Run B: stall cycles 5..7 (during the 5th read of point 0).
        do_go(0, 0, 0);
        repeat (4) @(posedge clk);
        #1 bus.stall = 1'b1;
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            chk("stall_dim_hold", int'(bus.dut__dim__address), 17);
            chk("stall_bvm_hold", int'(bus.dut__bvm__address), 4);
            chk("stall_dim_en", int'(bus.dut__dim__enable), 0);
            @(posedge clk);
        end
        #1 bus.stall = 1'b0;
        found = -1;
        for (int c = 8; c < 60 && found < 0; c++) begin
            @(negedge clk);
            if (bus.dut__out__write) found = c;
        end
        chk("stall_write_cycle", found, 18);
        wait_idle(2000, "runB");

        // Run C: random bases and stalls; go with new bases mid-run is ignored.
        do_go($urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 511));
        fin = 0;
        for (int c = 2; c < 6000 && fin == 0; c++) begin
            @(posedge clk); #1;
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.xxx__dut__go = (c == 50);
            if (c == 50) begin
                bus.cfg_in_base  = 9'($urandom_range(0, 511));
                bus.cfg_wt_base  = 10'($urandom_range(0, 1023));
                bus.cfg_out_base = 9'($urandom_range(0, 511));
            end
            @(negedge clk);
            if (bus.dut__xxx__finish) fin = c;
        end
        bus.stall = 1'b0;
        bus.xxx__dut__go = 1'b0;
        if (fin == 0) chk("runC_timeout", 0, 1);

        // Run D: reset at cycle 100 aborts; restart with wrapping bases.
        do_go($urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 511));
        repeat (99) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_finish", int'(bus.dut__xxx__finish), 1);
        chk("abort_strobes", int'({bus.dut__dim__enable, bus.dut__out__write, bus.clear, bus.acc_first}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        rq.delete();
        wq.delete();
        do_go(9'h1F8, $urandom_range(0, 1023), 9'h1FE);
        for (int i = 0; i < 4; i++) begin
            int exp_dim[4] = '{'h1F8, 'h1F9, 'h1FA, 'h008};
            @(negedge clk);
            chk("wrap_dim", int'(bus.dut__dim__address), exp_dim[i]);
        end
        wait_idle(2000, "runD");

        // Run E: small geometry instance.
        @(posedge clk); #1 bus2.xxx__dut__go = 1'b1;
        @(posedge clk); #1 bus2.xxx__dut__go = 1'b0;
        fin = -1;
        for (int c = 1; c < 200 && fin < 0; c++) begin
            @(negedge clk);
            if (bus2.dut__dim__enable) begin
                dq.push_back(int'(bus2.dut__dim__address));
                bq.push_back(int'(bus2.dut__bvm__address));
            end
            if (bus2.dut__out__write) wa.push_back(int'(bus2.dut__out__address));
            if (bus2.dut__xxx__finish) fin = c;
        end
        chk("e_finish_cycle", fin, 37);
        chk("e_reads", dq.size(), 24);
        chk("e_writes", wa.size(), 6);
        if (dq.size() == 24 && wa.size() == 6) begin
            int exp_d[4] = '{0, 1, 16, 17};
            for (int i = 0; i < 4; i++) begin
                chk("e_dim", dq[i], exp_d[i]);
                chk("e_bvm_f1", bq[12 + i], 16 + i);
            end
            for (int i = 0; i < 6; i++) chk("e_wr_addr", wa[i], i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Parametrised address/control sequencer for one convolution layer of the CNN datapath.
- Replaces hard-coded per-layer counter schedules: kernel size, output geometry, filter count, row stride, accumulator latency and base addresses are all configurable.
- Drives input data memory (dim) and b-vector memory (bvm) reads, accumulator first/last/clear tags, and result writes to a destination memory.
- Adds stall support and runtime base addresses.

Parameters:
- K, 3, kernel edge; K*K reads per output point
- ROW_STRIDE, 16, dim address distance between input rows
- OUT_W, 4, output points per row
- OUT_H, 4, output rows
- NUM_FILTERS, 4, filters processed sequentially
- WT_STRIDE, 16, bvm address distance between filters
- ACC_LAT, 5, cycles from last read to result valid (must be >=1)
- DIM_AW, 9, dim address width
- BVM_AW, 10, bvm address width
- OUT_AW, 9, output address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- xxx__dut__go  in  1  start pulse; sampled only in IDLE
- dut__xxx__finish  out  1  high when IDLE
- cfg_in_base  in  DIM_AW  dim base; captured on accepted go
- cfg_wt_base  in  BVM_AW  bvm base; captured on go
- cfg_out_base  in  OUT_AW  output base; captured on go
- stall  in  1  freezes sequencing while high
- dut__dim__address  out  DIM_AW  dim read address
- dut__dim__enable  out  1  dim read strobe
- dut__bvm__address  out  BVM_AW  bvm read address
- dut__bvm__enable  out  1  bvm read strobe
- dut__out__address  out  OUT_AW  result write address
- dut__out__enable  out  1  result memory enable
- dut__out__write  out  1  result write strobe
- acc_first  out  1  marks first read of a point
- acc_last  out  1  marks last read of a point
- clear  out  1  accumulator clear; equals dut__out__write

Behaviour:
- All outputs are registered or decoded from registered state only; no input-to-output combinational path except stall gating.
- Reset values: state IDLE, all indices 0, all enables/strobes/tags 0, all addresses 0, finish 1. Reset mid-run aborts immediately with no partial write.

State machine:
- IDLE: finish=1. Go accepted at edge E0 captures the bases, clears f/oy/ox/ky/kx and enters READ; finish=0 from E0. Go is ignored in all other states.
- READ: one read per non-stalled cycle, K*K cycles.
  - dim addr = in_base + (oy+ky)*ROW_STRIDE + ox + kx.
  - bvm addr = wt_base + f*WT_STRIDE + ky*K + kx.
  - dim/bvm enable = 1.
  - acc_first on (ky,kx)=(0,0); acc_last on (K-1,K-1).
  - kx increments, wrapping into ky. After the last read, go to DRAIN.
- DRAIN: ACC_LAT cycles, enables 0, then go to WRITE.
- WRITE: one cycle.
  - out enable=write=clear=1.
  - out addr = out_base + f*OUT_W*OUT_H + oy*OUT_W + ox.
  - Then advance ox; wrap to oy; wrap to f.
  - If the last point of the last filter was written, go to IDLE; else go to READ.
- Stall: in READ, DRAIN or WRITE, all counters/state hold; enables, write, clear and tags forced 0; addresses hold. A stalled WRITE is re-issued when stall drops.
- Arithmetic: unsigned, address sums truncated modulo 2^AW (wrap-around legal). Index counters sized $clog2 of their range.
- Timing with defaults, no stall:
  - 15 cycles per point (9 READ + 5 DRAIN + 1 WRITE), 960 cycles total.
  - Cycle 1 is the first READ after E0; writes occur at cycles 15, 30, ..., 960.
  - finish is high from cycle 961.
- Go in the same cycle as reset: reset wins.

Test Plan:
- Defaults, bases 0, go, no stall -> cycles 1-9:
  - dim 0,1,2,16,17,18,32,33,34; bvm 0-8.
  - acc_first at cycle 1, acc_last at cycle 9.
  - Write addr 0 at cycle 15.
  - 64 writes, last addr 63 at cycle 960; finish=1 at 961.
- Defaults, point order -> point 2 dim starts at 1; point 5 (oy=1) starts at 16; filter 1 bvm 16-24 with first out addr 16.
- Stall 3 cycles at 5th read of point 0 -> enables 0 with addresses held at 17/4; reads resume at 17/4; write at cycle 18.
- Go pulsed at cycle 50 during run -> ignored, schedule unchanged. Reset at cycle 100 -> next cycle finish=1 and all strobes 0; new go restarts at base addresses.
- cfg_in_base=0x1F8, cfg_out_base=0x1FE -> dim reads wrap (0x1F8, 0x1F9, 0x1FA, 0x008, ...); 3rd write goes to addr 0x000.
- K=2, OUT_W=3, OUT_H=1, NUM_FILTERS=2, ACC_LAT=1 -> 4 reads per point (dim 0,1,16,17), 6 cycles per point, 6 writes, finish at cycle 37.
